// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS core pipeline: machine word, fetch FSM states and
// the fetch-queue entry carried from the icache toward IF/ID.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH,
        STALL,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t npc;
    } fetch_entry_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched instructions between the icache and IF/ID.
// Pointers and count are reset; entry storage is data and is left unreset.
module fetch_queue
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, gates icache requests, buffers fetched
// words and presents {instruction, pc, npc} to IF/ID; handles redirect and halt.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000,
    parameter int    DEPTH    = 2
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  freeze,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    output logic  valid_out,
    output word_t instruction_out,
    output word_t pc_out,
    output word_t npc_out,
    output logic  halted
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t     state, state_next;
    word_t            pc;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] q_count;
    logic             q_full;
    logic             q_empty;
    fetch_entry_t     q_head;
    fetch_entry_t     q_wdata;

    assign imemaddr = pc;
    assign imemREN  = !RST && (state == FETCH) && !q_full && !redirect && !halt;
    assign push     = imemREN && ihit;
    assign pop      = valid_out && !freeze;
    assign q_wdata  = '{instr: imemload, pc: pc, npc: pc + PC_STEP};

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (q_wdata),
        .head  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign valid_out       = !q_empty;
    assign instruction_out = valid_out ? q_head.instr : '0;
    assign pc_out          = valid_out ? q_head.pc    : '0;
    assign npc_out         = valid_out ? q_head.npc   : '0;
    assign halted          = (state == HALTED);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            if (redirect)  pc <= redirect_pc & ~word_t'(3);
            else if (push) pc <= pc + PC_STEP;
        end
    end

    // STALL is left as soon as a slot frees so the next cycle can fetch again
    always_comb begin
        state_next = state;
        if (halt) begin
            state_next = HALTED;
        end else begin
            case (state)
                FETCH:   if (!redirect && push && !pop && q_count == CNT_W'(DEPTH - 1))
                             state_next = STALL;
                STALL:   if (redirect || pop || !q_full)
                             state_next = FETCH;
                HALTED:  state_next = HALTED;
                default: state_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of per-cycle vectors plus hand-written
// sequences for reset, address wraparound and asynchronous reset.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  ihit, freeze, redirect, halt;
    word_t redirect_pc, imemload, imemaddr;
    logic  imemREN, valid_out, halted;
    word_t instruction_out, pc_out, npc_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // icache model: the returned word encodes its own address
    assign imemload = 32'hC000_0000 | imemaddr;

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .CLK             (clk),
        .RST             (rst),
        .ihit            (ihit),
        .imemload        (imemload),
        .imemREN         (imemREN),
        .imemaddr        (imemaddr),
        .freeze          (freeze),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .valid_out       (valid_out),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .npc_out         (npc_out),
        .halted          (halted)
    );

    typedef struct {
        logic  ih, fz, rd;
        word_t rpc;
        logic  hl;
        logic  en;
        word_t addr;
        logic  vld;
        word_t pc;
        logic  hd;
    } vec_t;

    localparam int NV = 28;
    vec_t vt [NV];

    function automatic vec_t mk(logic ih, logic fz, logic rd, word_t rpc, logic hl,
                                logic en, word_t addr, logic vld, word_t pc, logic hd);
        vec_t v;
        v.ih = ih; v.fz = fz; v.rd = rd; v.rpc = rpc; v.hl = hl;
        v.en = en; v.addr = addr; v.vld = vld; v.pc = pc; v.hd = hd;
        return v;
    endfunction

    task automatic chk(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic en, input word_t addr,
                            input logic vld, input word_t pc, input logic hd);
        word_t e_instr, e_pc, e_npc;
        e_instr = vld ? (32'hC000_0000 | pc) : 32'h0;
        e_pc    = vld ? pc : 32'h0;
        e_npc   = vld ? pc + 32'd4 : 32'h0;
        chk({tag, "_en"},    32'(imemREN),    32'(en));
        chk({tag, "_addr"},  imemaddr,        addr);
        chk({tag, "_vld"},   32'(valid_out),  32'(vld));
        chk({tag, "_instr"}, instruction_out, e_instr);
        chk({tag, "_pc"},    pc_out,          e_pc);
        chk({tag, "_npc"},   npc_out,         e_npc);
        chk({tag, "_halt"},  32'(halted),     32'(hd));
    endtask

    task automatic set_in(input logic ih, input logic fz, input logic rd,
                          input word_t rpc, input logic hl);
        ihit = ih; freeze = fz; redirect = rd; redirect_pc = rpc; halt = hl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          ih fz rd rpc            hl   en addr          vld pc            hd
        vt[0]  = mk(1, 0, 0, 32'h0,         0,   1, 32'h0,        0, 32'h0,         0);
        vt[1]  = mk(1, 0, 0, 32'h0,         0,   1, 32'h4,        1, 32'h0,         0);
        vt[2]  = mk(1, 0, 0, 32'h0,         0,   1, 32'h8,        1, 32'h4,         0);
        vt[3]  = mk(1, 0, 0, 32'h0,         0,   1, 32'hC,        1, 32'h8,         0);
        vt[4]  = mk(1, 1, 0, 32'h0,         0,   1, 32'h10,       1, 32'hC,         0);
        vt[5]  = mk(1, 1, 0, 32'h0,         0,   0, 32'h14,       1, 32'hC,         0);
        vt[6]  = mk(1, 1, 0, 32'h0,         0,   0, 32'h14,       1, 32'hC,         0);
        vt[7]  = mk(1, 0, 0, 32'h0,         0,   0, 32'h14,       1, 32'hC,         0);
        vt[8]  = mk(1, 0, 0, 32'h0,         0,   1, 32'h14,       1, 32'h10,        0);
        vt[9]  = mk(0, 0, 0, 32'h0,         0,   1, 32'h18,       1, 32'h14,        0);
        vt[10] = mk(0, 0, 0, 32'h0,         0,   1, 32'h18,       0, 32'h0,         0);
        vt[11] = mk(1, 1, 0, 32'h0,         0,   1, 32'h18,       0, 32'h0,         0);
        vt[12] = mk(1, 1, 0, 32'h0,         0,   1, 32'h1C,       1, 32'h18,        0);
        vt[13] = mk(1, 1, 1, 32'h100,       0,   0, 32'h20,       1, 32'h18,        0);
        vt[14] = mk(0, 0, 0, 32'h0,         0,   1, 32'h100,      0, 32'h0,         0);
        vt[15] = mk(1, 0, 0, 32'h0,         0,   1, 32'h100,      0, 32'h0,         0);
        vt[16] = mk(1, 0, 1, 32'h103,       0,   0, 32'h104,      1, 32'h100,       0);
        vt[17] = mk(1, 0, 0, 32'h0,         0,   1, 32'h100,      0, 32'h0,         0);
        vt[18] = mk(1, 0, 0, 32'h0,         0,   1, 32'h104,      1, 32'h100,       0);
        vt[19] = mk(0, 0, 0, 32'h0,         0,   1, 32'h108,      1, 32'h104,       0);
        vt[20] = mk(0, 0, 0, 32'h0,         0,   1, 32'h108,      0, 32'h0,         0);
        vt[21] = mk(1, 1, 0, 32'h0,         0,   1, 32'h108,      0, 32'h0,         0);
        vt[22] = mk(1, 1, 0, 32'h0,         1,   0, 32'h10C,      1, 32'h108,       0);
        vt[23] = mk(1, 1, 0, 32'h0,         0,   0, 32'h10C,      1, 32'h108,       1);
        vt[24] = mk(1, 0, 0, 32'h0,         0,   0, 32'h10C,      1, 32'h108,       1);
        vt[25] = mk(1, 0, 0, 32'h0,         0,   0, 32'h10C,      0, 32'h0,         1);
        vt[26] = mk(1, 0, 1, 32'h200,       0,   0, 32'h10C,      0, 32'h0,         1);
        vt[27] = mk(1, 0, 0, 32'h0,         0,   0, 32'h200,      0, 32'h0,         1);

        rst = 1'b1;
        set_in(1, 0, 0, 32'h0, 0);
        #12;
        chk_outs("rst_held", 0, 32'h0, 0, 32'h0, 0);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            set_in(vt[i].ih, vt[i].fz, vt[i].rd, vt[i].rpc, vt[i].hl);
            #1;
            chk_outs($sformatf("v%0d", i), vt[i].en, vt[i].addr, vt[i].vld, vt[i].pc, vt[i].hd);
            next_cycle();
        end

        // reset leaves HALTED and restores the reset PC
        set_in(0, 0, 0, 32'h0, 0);
        rst = 1'b1;
        #1;
        chk_outs("halt_rst_held", 0, 32'h0, 0, 32'h0, 0);
        rst = 1'b0;
        #1;
        chk_outs("halt_rst_rel", 1, 32'h0, 0, 32'h0, 0);

        // PC wraps from 0xFFFF_FFFC to 0; misaligned target is truncated
        next_cycle();
        set_in(0, 0, 1, 32'hFFFF_FFFF, 0);
        next_cycle();
        set_in(1, 0, 0, 32'h0, 0);
        #1;
        chk_outs("wrap_req", 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
        next_cycle();
        set_in(0, 1, 0, 32'h0, 0);
        #1;
        chk_outs("wrap_head", 1, 32'h0, 1, 32'hFFFF_FFFC, 0);

        // fill the queue, then assert reset between clock edges
        set_in(1, 1, 0, 32'h0, 0);
        next_cycle();
        #1;
        chk_outs("full", 0, 32'h4, 1, 32'hFFFF_FFFC, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_outs("async_rst", 0, 32'h0, 0, 32'h0, 0);
        set_in(0, 0, 0, 32'h0, 0);
        #1;
        rst = 1'b0;
        #1;
        chk_outs("async_rel", 1, 32'h0, 0, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined MIPS core; sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues requests to the instruction cache. Buffers fetched instructions in a small queue and presents {instruction, pc, npc} to IF/ID.
- Decouples icache latency (ihit) from IF/ID freezes, and handles redirects (branch/jump) and halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, fetch-queue entries; power of two, >= 2.

Ports:
- CLK  in  1  core clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  icache returns imemload for the current imemaddr this cycle.
- imemload  in  32  instruction word from icache.
- imemREN  out  1  fetch request.
- imemaddr  out  32  fetch address (= PC register).
- freeze  in  1  IF/ID cannot accept; head entry must not pop.
- redirect  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  32  redirect target.
- halt  in  1  halt instruction seen; stop fetching permanently.
- valid_out  out  1  head entry valid.
- instruction_out  out  32  to IF/ID instructionin; 32'h0 (nop) when !valid_out.
- pc_out  out  32  to IF/ID pcin; 0 when !valid_out.
- npc_out  out  32  to IF/ID npcin (pc_out+4); 0 when !valid_out.
- halted  out  1  FSM in HALTED.

Behaviour:
- Reset (async, RST=1): PC=RESET_PC, queue empty (count=0, pointers 0), state FETCH. Outputs: imemREN=0 while RST held; valid_out=0, instruction_out/pc_out/npc_out=0, halted=0.
- FSM states:
  - FETCH: normal fetching.
  - STALL: queue full.
  - HALTED: fetching stopped.
- FSM transitions:
  - FETCH -> STALL when a push makes count==DEPTH without a simultaneous pop.
  - STALL -> FETCH when count<DEPTH.
  - Any state -> HALTED when halt=1.
  - HALTED exits only via reset.
- imemREN = (state==FETCH) && (count<DEPTH) && !redirect && !halt. Combinational; imemaddr = PC.
- Push: on an edge with imemREN && ihit, enqueue {imemload, PC, PC+4}; PC <= PC+4. 32-bit wraparound: 32'hFFFF_FFFC + 4 = 0.
- Latency: a pushed entry appears at the outputs the cycle after ihit when the queue was empty.
- Head outputs are driven combinationally from registered queue storage.
- Pop: on an edge with valid_out && !freeze, advance the read pointer.
- Push and pop in the same cycle: count unchanged, both take effect.
- No push occurs while full, even when popping that cycle; the freed slot is usable next cycle.
- Redirect (priority over everything except reset):
  - At the edge: queue flushed (count=0), PC <= {redirect_pc[31:2], 2'b00}.
  - Any same-cycle ihit is discarded and any same-cycle pop is moot.
  - Next cycle: valid_out=0, imemaddr=new PC.
  - State: STALL -> FETCH; HALTED stays HALTED (PC still updated, no fetch).
- Halt:
  - Blocks imemREN in the same cycle; latched into HALTED.
  - Already-queued entries continue to drain under normal pop rules.
- Queue pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- ihit while imemREN=0 is ignored.
- RST mid-transaction: immediate clear; no partial push.

Decomposition:
- cpu_types_pkg gains:
  - fetch_state_t enum {FETCH, STALL, HALTED}.
  - fetch_entry_t packed struct {word_t instr; word_t pc; word_t npc}.
  - Constant PC_STEP = 4.
- Sub-module fetch_queue: DEPTH-entry circular FIFO of fetch_entry_t.
  - Inputs: push, pop, flush.
  - Outputs: head, count, full, empty.
  - Same CLK/RST.
- fetch_unit holds PC, FSM, request gating.

Test Plan:
- Reset release, ihit=1 every cycle, freeze=0 -> imemaddr 0x0,0x4,0x8,...; valid_out rises one cycle after first ihit; pc_out/npc_out 0x0/0x4, then 0x4/0x8, each held one cycle.
- freeze=1 held 4 cycles with ihit=1 -> two pushes (pc 0x0,0x4), state STALL, imemREN=0, imemaddr=0x8; heads stay pc_out=0x0; on freeze release, pop resumes and imemREN returns the next cycle.
- Two entries queued, redirect=1 with redirect_pc=0x100 and ihit=1 -> next cycle valid_out=0, instruction_out=0, imemaddr=0x100, count=0; discarded ihit data never appears.
- redirect_pc=0x103 -> imemaddr=0x100; following fetch at 0x104.
- halt=1 with one entry queued -> imemREN=0 that cycle and thereafter; entry drains when freeze=0; halted=1; redirect to 0x200 updates imemaddr but imemREN stays 0; RST restores PC=0 and FETCH.
- RST asserted asynchronously mid-cycle with queue full -> valid_out=0, imemREN=0 immediately, no clock edge required.
